sel_sequencer: RTL



---
 rtl/sel_sequencer.sv | 128 ++++++++++++
 1 files changed

// File: rtl/sel_sequencer.sv
// Step-table stimulus sequencer driving A/B/C/SEL1/SEL2 of the top selection datapath.
// Optional build macro SEL_SEQUENCER_LOOP_EN: wrap to step 0 after the last step instead of finishing.
module sel_sequencer #(
  parameter int DWELL_W   = 8,
  parameter int LAST_STEP = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [1:0]         wr_addr,
  input  logic [DWELL_W+6:0] wr_data,
  input  logic               start,
  input  logic               abort,
  output logic               A,
  output logic               B,
  output logic               C,
  output logic [1:0]         SEL1,
  output logic [1:0]         SEL2,
  output logic               busy,
  output logic               strobe,
  output logic               done
);

  localparam int EW = DWELL_W + 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, next_state;
  logic [EW-1:0]        table_q [4];
  logic [1:0]           step;
  logic [DWELL_W-1:0]   cnt;
  logic [6:0]           drive;
  logic                 last_cycle, at_last_step, load;
  logic [1:0]           load_idx;
  logic [EW-1:0]        load_entry;
  logic [DWELL_W-1:0]   load_dwell;

  assign last_cycle   = (cnt == DWELL_W'(1));
  assign at_last_step = (step == 2'(LAST_STEP));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: if (start && !abort) next_state = RUN;
      RUN: begin
        if (abort) next_state = IDLE;
`ifdef SEL_SEQUENCER_LOOP_EN
        else       next_state = RUN;
`else
        else if (last_cycle && at_last_step) next_state = DONE;
`endif
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // A load happens on run entry and on every step boundary that stays in RUN.
  always_comb begin
    load     = 1'b0;
    load_idx = '0;
    if (state == IDLE && next_state == RUN) begin
      load = 1'b1;
    end else if (state == RUN && !abort && last_cycle) begin
      if (!at_last_step) begin
        load     = 1'b1;
        load_idx = step + 2'd1;
      end
`ifdef SEL_SEQUENCER_LOOP_EN
      else begin
        load = 1'b1;
      end
`endif
    end
  end

  assign load_entry = table_q[load_idx];
  assign load_dwell = (load_entry[DWELL_W-1:0] == '0) ? DWELL_W'(1) : load_entry[DWELL_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 4; i++) table_q[i] <= '0;
      step  <= '0;
      cnt   <= '0;
      drive <= '0;
    end else begin
      if (wr_en && !busy) table_q[wr_addr] <= wr_data;
      if (load) begin
        step  <= load_idx;
        cnt   <= load_dwell;
        drive <= load_entry[EW-1:DWELL_W];
      end else if (next_state != RUN) begin
        step  <= '0;
        cnt   <= '0;
        drive <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - DWELL_W'(1);
      end
    end
  end

`ifdef SEL_SEQUENCER_LOOP_EN
  logic wrap_q;

  // Flags the first cycle of each repeated pass; the initial pass is not a wrap.
  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= load && (state == RUN) && (load_idx == 2'd0);
  end
`endif

  always_comb begin
    {A, B, C, SEL1, SEL2} = drive;
    busy   = (state == RUN);
    strobe = (state == RUN) && last_cycle;
`ifdef SEL_SEQUENCER_LOOP_EN
    done   = wrap_q;
`else
    done   = (state == DONE);
`endif
  end

endmodule
